// File: rtl/kdtree_stream_router_if.sv
// Bundle of the router's load handshake, FIFO head and memory-write buses.
// Latency: none; this is wiring only.
// Backpressure: the FIFO side is show-ahead; the router pops with in_fifo_deq.
interface kdtree_stream_router_if #(
   parameter int DATA_WIDTH = 11,
   parameter int LEAF_SIZE  = 8,
   parameter int PATCH_SIZE = 5,
   parameter int NUM_LEAVES = 64,
   parameter int NUM_QUERYS = 494
);
   localparam int NUM_NODES = NUM_LEAVES - 1;

   logic                               load_kdtree;
   logic [DATA_WIDTH-1:0]              in_fifo_rdata;
   logic                               in_fifo_rempty_n;
   logic                               in_fifo_deq;

   logic                               node_wen;
   logic [$clog2(NUM_NODES)-1:0]       node_waddr;
   logic [2*DATA_WIDTH-1:0]            node_wdata;

   logic                               leaf_wen;
   logic [$clog2(NUM_LEAVES)-1:0]      leaf_waddr;
   logic [$clog2(LEAF_SIZE)-1:0]       leaf_wslot;
   logic [PATCH_SIZE*DATA_WIDTH-1:0]   leaf_wdata;
   logic [DATA_WIDTH-1:0]              leaf_widx;

   logic                               query_wen;
   logic [$clog2(NUM_QUERYS)-1:0]      query_waddr;
   logic [PATCH_SIZE*DATA_WIDTH-1:0]   query_wdata;

   logic                               busy;
   logic                               load_done;

   // router side
   modport master (
      input  load_kdtree, in_fifo_rdata, in_fifo_rempty_n,
      output in_fifo_deq,
      output node_wen, node_waddr, node_wdata,
      output leaf_wen, leaf_waddr, leaf_wslot, leaf_wdata, leaf_widx,
      output query_wen, query_waddr, query_wdata,
      output busy, load_done
   );

   // host FIFO / memory side
   modport slave (
      output load_kdtree, in_fifo_rdata, in_fifo_rempty_n,
      input  in_fifo_deq,
      input  node_wen, node_waddr, node_wdata,
      input  leaf_wen, leaf_waddr, leaf_wslot, leaf_wdata, leaf_widx,
      input  query_wen, query_waddr, query_wdata,
      input  busy, load_done
   );
endinterface

// File: rtl/kdtree_stream_router.sv
// Drains the host word stream into node, leaf and query memories (KDTREE_ROUTER_QUERY_EN enables the query phase).
// Latency: one wide write strobe the cycle after a record's last word is popped; 1 word/cycle.
// Backpressure: pops only when the FIFO head is valid; empty cycles stall assembly without loss.
module kdtree_stream_router #(
   parameter int DATA_WIDTH = 11,
   parameter int LEAF_SIZE  = 8,
   parameter int PATCH_SIZE = 5,
   parameter int NUM_LEAVES = 64,
   parameter int NUM_QUERYS = 494
) (
   input logic                     clk,
   input logic                     rst,
   kdtree_stream_router_if.master  io
);
   localparam int DW        = DATA_WIDTH;
   localparam int NUM_NODES = NUM_LEAVES - 1;
   localparam int NAW       = $clog2(NUM_NODES);
   localparam int LAW       = $clog2(NUM_LEAVES);
   localparam int SW        = $clog2(LEAF_SIZE);
   localparam int QAW       = $clog2(NUM_QUERYS);
   localparam int PW        = PATCH_SIZE * DW;
   localparam int WCW       = $clog2(PATCH_SIZE + 1);

   localparam logic [NAW-1:0] NODE_LAST  = NAW'(NUM_NODES - 1);
   localparam logic [LAW-1:0] LEAF_LAST  = LAW'(NUM_LEAVES - 1);
   localparam logic [SW-1:0]  SLOT_LAST  = SW'(LEAF_SIZE - 1);
   localparam logic [WCW-1:0] WC_NODE    = WCW'(1);
   localparam logic [WCW-1:0] WC_LEAF    = WCW'(PATCH_SIZE);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      NODES   = 3'd1,
      LEAVES  = 3'd2,
      QUERIES = 3'd3,
      DONE    = 3'd4
   } state_t;

   state_t          state;
   logic [WCW-1:0]  wcnt;
   logic [PW-1:0]   asm_q;
   logic [PW-1:0]   asm_nxt;
   logic [NAW-1:0]  node_cnt;
   logic [LAW-1:0]  leaf_cnt;
   logic [SW-1:0]   slot_cnt;
   logic            deq;

   logic            node_wen;
   logic [NAW-1:0]  node_waddr;
   logic [2*DW-1:0] node_wdata;
   logic            leaf_wen;
   logic [LAW-1:0]  leaf_waddr;
   logic [SW-1:0]   leaf_wslot;
   logic [PW-1:0]   leaf_wdata;
   logic [DW-1:0]   leaf_widx;
   logic            busy;
   logic            load_done;

`ifdef KDTREE_ROUTER_QUERY_EN
   localparam logic [QAW-1:0] QUERY_LAST = QAW'(NUM_QUERYS - 1);
   localparam logic [WCW-1:0] WC_QUERY   = WCW'(PATCH_SIZE - 1);
   logic [QAW-1:0]  query_cnt;
   logic            query_wen;
   logic [QAW-1:0]  query_waddr;
   logic [PW-1:0]   query_wdata;
`endif

   // Pop whenever a word is offered during one of the three load phases.
   assign deq = io.in_fifo_rempty_n &&
                ((state == NODES) || (state == LEAVES) || (state == QUERIES));

   // Assembly register with the current head word dropped into slot wcnt (word k at bits k*DW).
   always_comb begin
      asm_nxt = asm_q;
      for (int k = 0; k < PATCH_SIZE; k++) begin
         if (wcnt == WCW'(k)) asm_nxt[k*DW +: DW] = io.in_fifo_rdata;
      end
   end

   // Load FSM: word counting, record assembly and registered write strobes.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         wcnt       <= '0;
         asm_q      <= '0;
         node_cnt   <= '0;
         leaf_cnt   <= '0;
         slot_cnt   <= '0;
         node_wen   <= 1'b0;
         node_waddr <= '0;
         node_wdata <= '0;
         leaf_wen   <= 1'b0;
         leaf_waddr <= '0;
         leaf_wslot <= '0;
         leaf_wdata <= '0;
         leaf_widx  <= '0;
         busy       <= 1'b0;
         load_done  <= 1'b0;
`ifdef KDTREE_ROUTER_QUERY_EN
         query_cnt   <= '0;
         query_wen   <= 1'b0;
         query_waddr <= '0;
         query_wdata <= '0;
`endif
      end else begin
         node_wen <= 1'b0;
         leaf_wen <= 1'b0;
`ifdef KDTREE_ROUTER_QUERY_EN
         query_wen <= 1'b0;
`endif
         case (state)
            IDLE, DONE: begin
               if (io.load_kdtree) begin
                  state     <= NODES;
                  busy      <= 1'b1;
                  load_done <= 1'b0;
                  wcnt      <= '0;
                  asm_q     <= '0;
                  node_cnt  <= '0;
                  leaf_cnt  <= '0;
                  slot_cnt  <= '0;
`ifdef KDTREE_ROUTER_QUERY_EN
                  query_cnt <= '0;
`endif
               end
            end
            NODES: begin
               if (deq) begin
                  if (wcnt == WC_NODE) begin
                     node_wen   <= 1'b1;
                     node_waddr <= node_cnt;
                     node_wdata <= asm_nxt[2*DW-1:0];
                     wcnt       <= '0;
                     if (node_cnt == NODE_LAST) state <= LEAVES;
                     else                       node_cnt <= node_cnt + 1'b1;
                  end else begin
                     asm_q <= asm_nxt;
                     wcnt  <= wcnt + 1'b1;
                  end
               end
            end
            LEAVES: begin
               if (deq) begin
                  if (wcnt == WC_LEAF) begin
                     // sixth word is the patch's original-image index, not data
                     leaf_wen   <= 1'b1;
                     leaf_waddr <= leaf_cnt;
                     leaf_wslot <= slot_cnt;
                     leaf_wdata <= asm_q;
                     leaf_widx  <= io.in_fifo_rdata;
                     wcnt       <= '0;
                     if (slot_cnt == SLOT_LAST) begin
                        slot_cnt <= '0;
                        if (leaf_cnt == LEAF_LAST) begin
`ifdef KDTREE_ROUTER_QUERY_EN
                           state <= QUERIES;
`else
                           state     <= DONE;
                           busy      <= 1'b0;
                           load_done <= 1'b1;
`endif
                        end else begin
                           leaf_cnt <= leaf_cnt + 1'b1;
                        end
                     end else begin
                        slot_cnt <= slot_cnt + 1'b1;
                     end
                  end else begin
                     asm_q <= asm_nxt;
                     wcnt  <= wcnt + 1'b1;
                  end
               end
            end
`ifdef KDTREE_ROUTER_QUERY_EN
            QUERIES: begin
               if (deq) begin
                  if (wcnt == WC_QUERY) begin
                     query_wen   <= 1'b1;
                     query_waddr <= query_cnt;
                     query_wdata <= asm_nxt;
                     wcnt        <= '0;
                     if (query_cnt == QUERY_LAST) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        load_done <= 1'b1;
                     end else begin
                        query_cnt <= query_cnt + 1'b1;
                     end
                  end else begin
                     asm_q <= asm_nxt;
                     wcnt  <= wcnt + 1'b1;
                  end
               end
            end
`endif
            default: begin
               state     <= IDLE;
               busy      <= 1'b0;
               load_done <= 1'b0;
            end
         endcase
      end
   end

   assign io.in_fifo_deq = deq;
   assign io.node_wen    = node_wen;
   assign io.node_waddr  = node_waddr;
   assign io.node_wdata  = node_wdata;
   assign io.leaf_wen    = leaf_wen;
   assign io.leaf_waddr  = leaf_waddr;
   assign io.leaf_wslot  = leaf_wslot;
   assign io.leaf_wdata  = leaf_wdata;
   assign io.leaf_widx   = leaf_widx;
   assign io.busy        = busy;
   assign io.load_done   = load_done;
`ifdef KDTREE_ROUTER_QUERY_EN
   assign io.query_wen   = query_wen;
   assign io.query_waddr = query_waddr;
   assign io.query_wdata = query_wdata;
`else
   assign io.query_wen   = 1'b0;
   assign io.query_waddr = QAW'(0);
   assign io.query_wdata = PW'(0);
`endif
endmodule

// File: tb/tb_kdtree_stream_router.sv
// Randomized bench for kdtree_stream_router against a word-position reference model.
// Latency: checks strobes one cycle after each record's last pop, load_done after the final word.
// Backpressure: FIFO head validity is randomly withheld to insert bubbles.
module tb_kdtree_stream_router;
   localparam int DW         = 11;
   localparam int NODE_WORDS = 126;
   localparam int LEAF_END   = 3198;
`ifdef KDTREE_ROUTER_QUERY_EN
   localparam int TOTAL      = 5668;
   localparam int EXP_Q      = 494;
`else
   localparam int TOTAL      = 3198;
   localparam int EXP_Q      = 0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;

   kdtree_stream_router_if io ();
   kdtree_stream_router dut (.clk(clk), .rst(rst), .io(io));

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic [DW-1:0] stream [TOTAL];

   // reference model state
   bit    started = 0;
   int    consumed = 0;
   bit    exp_n = 0, exp_l = 0, exp_q = 0;
   bit    exp_busy = 0, exp_done = 0;
   logic [5:0]  e_naddr;
   logic [21:0] e_ndata;
   logic [5:0]  e_laddr;
   logic [2:0]  e_slot;
   logic [54:0] e_ldata;
   logic [10:0] e_widx;
   logic [8:0]  e_qaddr;
   logic [54:0] e_qdata;

   // observation bookkeeping
   int cyc = 0;
   int pulse_cyc, first_deq_cyc, done_cyc;
   int n_writes, l_writes, q_writes, last_qaddr;
   logic [5:0]  first_naddr;
   logic [21:0] first_ndata;
   logic [54:0] first_ldata;
   logic [10:0] first_lidx;
   logic [5:0]  ninth_laddr;
   logic [2:0]  ninth_slot;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic fill_stream(input bit fixed);
      for (int i = 0; i < TOTAL; i++) stream[i] = DW'($urandom);
      if (fixed) begin
         stream[0] = 11'd3;   stream[1] = 11'd517;
         stream[126] = 11'd1; stream[127] = 11'd2; stream[128] = 11'd3;
         stream[129] = 11'd4; stream[130] = 11'd5; stream[131] = 11'd77;
      end
   endtask

   // Which record (if any) ends at stream position i, and what it should contain.
   task automatic expect_record(input int i);
      int j, k;
      if (i < NODE_WORDS) begin
         if (i % 2 == 1) begin
            exp_n   = 1;
            e_naddr = 6'(i / 2);
            e_ndata = {stream[i], stream[i-1]};
         end
      end else if (i < LEAF_END) begin
         j = i - NODE_WORDS;
         if (j % 6 == 5) begin
            k       = j / 6;
            exp_l   = 1;
            e_laddr = 6'(k / 8);
            e_slot  = 3'(k % 8);
            e_ldata = {stream[i-1], stream[i-2], stream[i-3], stream[i-4], stream[i-5]};
            e_widx  = stream[i];
         end
      end else begin
         j = i - LEAF_END;
         if (j % 5 == 4) begin
            exp_q   = 1;
            e_qaddr = 9'(j / 5);
            e_qdata = {stream[i], stream[i-1], stream[i-2], stream[i-3], stream[i-4]};
         end
      end
   endtask

   // One clock: check outputs at the falling edge, then drive the next inputs.
   task automatic cycle(input bit pulse, input bit do_rst, input int bubble_pct);
      bit loading, offer;
      @(negedge clk);
      cyc++;
      check_eq("wen", {io.node_wen, io.leaf_wen, io.query_wen}, {exp_n, exp_l, exp_q});
      if (exp_n) begin
         check_eq("node_waddr", io.node_waddr, e_naddr);
         check_eq("node_wdata", io.node_wdata, e_ndata);
      end
      if (exp_l) begin
         check_eq("leaf_waddr", io.leaf_waddr, e_laddr);
         check_eq("leaf_wslot", io.leaf_wslot, e_slot);
         check_eq("leaf_wdata", io.leaf_wdata, e_ldata);
         check_eq("leaf_widx", io.leaf_widx, e_widx);
      end
      if (exp_q) begin
         check_eq("query_waddr", io.query_waddr, e_qaddr);
         check_eq("query_wdata", io.query_wdata, e_qdata);
      end
      check_eq("busy", io.busy, exp_busy);
      check_eq("load_done", io.load_done, exp_done);
      if (io.node_wen) begin
         if (n_writes == 0) begin first_naddr = io.node_waddr; first_ndata = io.node_wdata; end
         n_writes++;
      end
      if (io.leaf_wen) begin
         if (l_writes == 0) begin first_ldata = io.leaf_wdata; first_lidx = io.leaf_widx; end
         if (l_writes == 8) begin ninth_laddr = io.leaf_waddr; ninth_slot = io.leaf_wslot; end
         l_writes++;
      end
      if (io.query_wen) begin
         q_writes++;
         last_qaddr = int'(io.query_waddr);
      end
      if (io.load_done && done_cyc < 0 && first_deq_cyc >= 0) done_cyc = cyc;

      exp_n = 0; exp_l = 0; exp_q = 0;
      rst = do_rst;
      io.load_kdtree = pulse;
      offer = !do_rst && ($urandom_range(99) >= bubble_pct);
      io.in_fifo_rempty_n = offer;
      io.in_fifo_rdata = (consumed < TOTAL) ? stream[consumed] : DW'($urandom);
      #1;
      loading = started && (consumed < TOTAL);
      check_eq("deq", io.in_fifo_deq, offer && loading);
      if (offer && loading) begin
         if (consumed == 0) first_deq_cyc = cyc;
         expect_record(consumed);
         consumed++;
      end
      if (do_rst) begin
         started  = 0;
         consumed = 0;
      end else if (pulse && !loading) begin
         started  = 1;
         consumed = 0;
      end
      exp_busy = started && (consumed < TOTAL);
      exp_done = started && (consumed == TOTAL);
   endtask

   task automatic run_load(input int bubble, input int pulse_at, input int abort_at);
      int budget;
      bit pulsed;
      budget = 0; pulsed = 0;
      n_writes = 0; l_writes = 0; q_writes = 0; last_qaddr = -1;
      first_deq_cyc = -1; done_cyc = -1;
      cycle(1, 0, bubble);
      pulse_cyc = cyc;
      while (!exp_done) begin
         if (abort_at >= 0 && consumed == abort_at) break;
         if (budget >= 30000) begin
            check_eq("load_timeout", 1, 0);
            break;
         end
         if (!pulsed && pulse_at >= 0 && consumed >= pulse_at) begin
            pulsed = 1;
            cycle(1, 0, bubble);
         end else begin
            cycle(0, 0, bubble);
         end
         budget++;
      end
      if (abort_at < 0) repeat (3) cycle(0, 0, bubble);
   endtask

   task automatic check_counts();
      check_eq("node_writes", n_writes, 63);
      check_eq("leaf_writes", l_writes, 512);
      check_eq("query_writes", q_writes, EXP_Q);
`ifdef KDTREE_ROUTER_QUERY_EN
      check_eq("last_query_waddr", last_qaddr, 493);
`endif
      check_eq("final_load_done", io.load_done, 1);
      check_eq("final_busy", io.busy, 0);
   endtask

   initial begin
      io.load_kdtree = 1'b0;
      io.in_fifo_rdata = '0;
      io.in_fifo_rempty_n = 1'b1;
      rst = 1'b1;

      // reset with a valid FIFO head offered
      repeat (3) begin
         @(negedge clk);
         check_eq("rst_deq", io.in_fifo_deq, 0);
         check_eq("rst_wen", {io.node_wen, io.leaf_wen, io.query_wen}, 3'b000);
         check_eq("rst_busy", io.busy, 0);
         check_eq("rst_load_done", io.load_done, 0);
         check_eq("rst_node_bus", {io.node_waddr, io.node_wdata}, 0);
         check_eq("rst_leaf_bus", {io.leaf_waddr, io.leaf_wslot, io.leaf_widx}, 0);
         check_eq("rst_leaf_wdata", io.leaf_wdata, 0);
         check_eq("rst_query_bus", {io.query_waddr, io.query_wdata}, 0);
      end
      repeat (3) cycle(0, 0, 0);

      // load 1: fixed first records, 30% bubbles
      fill_stream(1);
      run_load(30, -1, -1);
      check_counts();
      check_eq("first_node_waddr", first_naddr, 0);
      check_eq("first_node_wdata", first_ndata, {11'd517, 11'd3});
      check_eq("first_leaf_w0", first_ldata[10:0], 11'd1);
      check_eq("first_leaf_w4", first_ldata[54:44], 11'd5);
      check_eq("first_leaf_widx", first_lidx, 11'd77);
      check_eq("ninth_leaf_waddr", ninth_laddr, 1);
      check_eq("ninth_leaf_wslot", ninth_slot, 0);

      // load 2: restart from DONE, no bubbles, stray pulse mid-LEAVES
      fill_stream(0);
      run_load(0, 500, -1);
      check_counts();
      check_eq("first_deq_latency", first_deq_cyc - pulse_cyc, 1);
      check_eq("done_latency", done_cyc - first_deq_cyc, TOTAL);

      // load 3: reset in the middle of the fourth leaf patch
      fill_stream(0);
      run_load(20, -1, NODE_WORDS + 6*3 + 2);
      cycle(0, 1, 0);
      repeat (6) cycle(0, 0, 0);
      check_eq("abort_leaf_writes", l_writes, 3);
      check_eq("abort_busy", io.busy, 0);

      // load 4: reload after reset starts at node 0
      fill_stream(1);
      run_load(30, -1, -1);
      check_counts();
      check_eq("reload_first_node_waddr", first_naddr, 0);
      check_eq("reload_first_node_wdata", first_ndata, {11'd517, 11'd3});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/kdtree_stream_router.md
# kdtree_stream_router

Input-side stage between the 11-bit host input FIFO and the accelerator's storage. After a `load_kdtree` pulse it drains the FIFO's single word stream in a fixed order: internal nodes, then leaf patches, then query patches. It assembles each multi-word record and issues one wide write per record to node, leaf or query memory, then signals `load_done` so the host can raise `fsm_start`.

## Interface
Parameters:
- `DATA_WIDTH`, 11, width of one stream word
- `LEAF_SIZE`, 8, patches per leaf
- `PATCH_SIZE`, 5, data words per patch
- `NUM_LEAVES`, 64, leaves; `NUM_NODES` = `NUM_LEAVES`-1
- `NUM_QUERYS`, 494, query patches (26x19)

Ports:
- `clk` in 1: single clock
- `rst` in 1: reset, synchronous, active-high
- `load_kdtree` in 1: one-cycle start pulse
- `in_fifo_rdata` in `DATA_WIDTH`: FIFO head word, show-ahead
- `in_fifo_rempty_n` in 1: FIFO head valid
- `in_fifo_deq` out 1: pop head this cycle
- `node_wen` out 1; `node_waddr` out clog2(`NUM_NODES`); `node_wdata` out 2*`DATA_WIDTH`: {median, index}
- `leaf_wen` out 1; `leaf_waddr` out clog2(`NUM_LEAVES`); `leaf_wslot` out clog2(`LEAF_SIZE`); `leaf_wdata` out `PATCH_SIZE`*`DATA_WIDTH`; `leaf_widx` out `DATA_WIDTH`
- `query_wen` out 1; `query_waddr` out clog2(`NUM_QUERYS`); `query_wdata` out `PATCH_SIZE`*`DATA_WIDTH`
- `busy` out 1: a load is in progress
- `load_done` out 1: level, high after a complete load

## Operation
- States: IDLE -> NODES -> LEAVES -> QUERIES -> DONE. DONE -> NODES on `load_kdtree`. IDLE -> NODES on `load_kdtree`.
- `load_kdtree` in NODES, LEAVES or QUERIES is ignored.
- `in_fifo_deq` = `in_fifo_rempty_n` && state is NODES, LEAVES or QUERIES. This is combinational. A word is consumed in every cycle where `in_fifo_deq` is high.
- NODES: 2 words per node, index then median. Address runs 0..`NUM_NODES`-1.
- LEAVES: 6 words per patch: 5 data words, then the patch's original-image index. The slot counter runs 0..7 inside a leaf, and the leaf counter runs 0..63. Slot wraps to 0 and leaf increments when slot is 7.
- QUERIES: 5 data words per patch. Address runs 0..`NUM_QUERYS`-1.
- Packing: word k of a patch goes to bits [k*DW +: DW], so the first word is in the LSBs.
- Phase change happens on the cycle the last word of the phase is consumed. The next word goes to the new phase.
- Counters and assembly registers clear when entering NODES.
- `busy` is high in NODES, LEAVES and QUERIES. `load_done` is high in DONE.

## Timing
- Reset: state IDLE, all counters 0, all `*_wen`/`busy`/`load_done`/`in_fifo_deq` 0, all address and data outputs 0.
- Entering NODES takes 1 cycle after the `load_kdtree` pulse. The first deq can happen on that next cycle.
- Throughput is 1 word per cycle. An empty FIFO inserts bubbles with no loss of assembly state.
- Write strobe: registered and one cycle wide. It is asserted the cycle after the last word of a record is dequeued. Address and data are valid in the same cycle as the strobe.
- Back-to-back records produce strobes on consecutive record boundaries. Strobes from different memories are never asserted together.
- Completion: the final record write and `busy`=0/`load_done`=1 occur in the same cycle. A full load with no bubbles is 126+3072+2470 = 5668 words, so `load_done` rises 5668 cycles after the first deq cycle.
- `rst` during a load: on the next edge, return to reset state. A partial record is discarded and no strobe is issued.

## Configuration
- `KDTREE_ROUTER_QUERY_EN` defined: behaviour as described above.
- `KDTREE_ROUTER_QUERY_EN` undefined:
  - The QUERIES state and the `query_*` logic are removed.
  - `query_wen` is tied to 0, and `query_waddr`/`query_wdata` are tied to 0.
  - LEAVES goes straight to DONE, and a full load is 3198 words.

## Test plan
- Reset: hold `rst`=1 for 3 cycles with `in_fifo_rempty_n`=1. Required: no deq, all outputs 0, `load_done`=0.
- First node: pulse `load_kdtree`, then send words 3, 517. Required: one `node_wen` with `node_waddr`=0 and `node_wdata`={517,3}, one cycle after 517 is dequeued.
- Leaf packing: stream 126 node words, then 1,2,3,4,5,77. Required: `leaf_wen` with waddr 0, wslot 0, `leaf_wdata`[10:0]=1, `leaf_wdata`[54:44]=5, `leaf_widx`=77. The 9th patch writes waddr 1, wslot 0.
- Full load with random bubbles (`rempty_n` deasserted 30% of cycles). Required: exactly 63/512/494 writes to node/leaf/query memory, last `query_waddr`=493, then `load_done`=1 and `busy`=0.
- Pulse `load_kdtree` mid-LEAVES. Required: ignored, counters unchanged. Assert `rst` mid-patch, then reload. Required: no write for the partial patch, and the reload starts at `node_waddr` 0.
- Macro undefined: full stream of 3198 words. Required: `load_done` after the 512th leaf write, `query_wen` never 1, and the FIFO is not dequeued after that point.
